// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared state type and constants for the fetch sequencer.
// Imported by pc_fetch_ctrl and its testbench.
package pc_fetch_ctrl_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0] INSTR_ALIGN = 2'b00;
    localparam int PC_INC = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD,
        FAULT
    } state_t;
endpackage

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer driving ProgramCounter, imem req/ack and decode valid/ready.
// Build option PC_FETCH_CTRL_MISALIGN_CHECK_EN: misaligned redirect enters a sticky FAULT.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [XLEN-1:0] pc,
    output logic            pc_next,
    output logic            load_en,
    output logic [XLEN-1:0] load,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fault
);

    state_t          state, state_nx;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] addr_nx;
    logic            bad;
    logic            redir;
    logic            ld_addr;
    logic            take;

`ifdef PC_FETCH_CTRL_MISALIGN_CHECK_EN
    assign bad   = redirect_valid && (redirect_target[1:0] != INSTR_ALIGN);
    assign tgt   = redirect_target;
    assign fault = (state == FAULT);
`else
    localparam logic [XLEN-1:0] ADDR_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    assign bad   = 1'b0;
    assign tgt   = redirect_target & ADDR_MASK;
    assign fault = 1'b0;
`endif

    assign redir = redirect_valid && !bad && (state != FAULT);

    always_comb begin
        state_nx    = state;
        ld_addr     = 1'b0;
        addr_nx     = redir ? tgt : pc;
        take        = 1'b0;
        pc_next     = 1'b0;
        load_en     = redir;
        load        = redir ? tgt : '0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = FETCH;
                ld_addr  = 1'b1;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redir) begin
                    // ack in the redirect cycle is squashed in place
                    if (imem_ack) ld_addr = 1'b1;
                    else          state_nx = DRAIN;
                end else if (imem_ack) begin
                    take     = 1'b1;
                    pc_next  = 1'b1;
                    state_nx = HOLD;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nx = FETCH;
                    ld_addr  = 1'b1;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (redir || instr_ready) begin
                    state_nx = FETCH;
                    ld_addr  = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef PC_FETCH_CTRL_MISALIGN_CHECK_EN
        if (bad && state != FAULT) begin
            state_nx = FAULT;
            ld_addr  = 1'b0;
            take     = 1'b0;
            pc_next  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            imem_addr <= '0;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            state <= state_nx;
            if (ld_addr) imem_addr <= addr_nx;
            if (take) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench with a ProgramCounter model and an expected-instruction queue.
// Covers streaming, delayed ack, redirects in HOLD/FETCH/DRAIN, misalignment, async reset, PC wrap.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    logic        clk;
    logic        clr_n;
    logic [31:0] pc;
    logic        pc_next;
    logic        load_en;
    logic [31:0] load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_fetch_ctrl #(.XLEN(32)) dut (
        .clk             (clk),
        .clr_n           (clr_n),
        .pc              (pc),
        .pc_next         (pc_next),
        .load_en         (load_en),
        .load            (load),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ProgramCounter stand-in: load wins over increment, wraps mod 2^32
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)       pc <= RESET_PC;
        else if (load_en) pc <= load;
        else if (pc_next) pc <= pc + 32'(PC_INC);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   imem_req,    0);
        chk({tag, "_addr"},  imem_addr,   0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr,       0);
        chk({tag, "_ipc"},   instr_pc,    0);
        chk({tag, "_pcnx"},  pc_next,     0);
        chk({tag, "_lden"},  load_en,     0);
        chk({tag, "_load"},  load,        0);
        chk({tag, "_fault"}, fault,       0);
    endtask

    // ends at a negedge with the DUT in its first FETCH cycle
    task automatic do_reset();
        clr_n = 1'b0;
        idle_inputs();
        sb.delete();
        tick();
        tick();
        #1;
        chk_all_zero("rst");
        clr_n = 1'b1;
        #1;
        chk("idle_req", imem_req, 0);
        chk("idle_valid", instr_valid, 0);
        tick();
        #1;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, RESET_PC);
    endtask

    task automatic fetch_ack(input int wait_n, input logic [31:0] a,
                             input logic [31:0] d);
        for (int i = 0; i < wait_n; i++) begin
            imem_ack = 1'b0;
            #1;
            chk("req_wait", imem_req, 1);
            chk("addr_stable", imem_addr, a);
            chk("pcnx_wait", pc_next, 0);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = d;
        #1;
        chk("req_ack", imem_req, 1);
        chk("addr_ack", imem_addr, a);
        chk("pcnx_ack", pc_next, 1);
        sb.push_back('{a, d});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic accept();
        exp_t e;
        instr_ready = 1'b1;
        #1;
        chk("valid", instr_valid, 1);
        chk("pcnx_hold", pc_next, 0);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("instr", instr, e.data);
            chk("instr_pc", instr_pc, e.addr);
        end
        tick();
        instr_ready = 1'b0;
        #1;
        chk("valid_drop", instr_valid, 0);
    endtask

    task automatic drop_expected();
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        clr_n = 1'b0;
        idle_inputs();

        // streaming with immediate ack
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_ack(0, 32'(i * 4), dat(32'(i * 4)));
            accept();
        end

        // ack delayed three cycles
        fetch_ack(3, 32'h10, dat(32'h10));
        accept();

        // redirect in HOLD with ready high
        do_reset();
        fetch_ack(0, 32'h0, dat(32'h0));
        accept();
        fetch_ack(0, 32'h4, dat(32'h4));
        accept();
        fetch_ack(0, 32'h8, dat(32'h8));
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        chk("hold_rd_lden", load_en, 1);
        chk("hold_rd_load", load, 32'h100);
        chk("hold_rd_pcnx", pc_next, 0);
        chk("hold_rd_ipc", instr_pc, 32'h8);
        drop_expected();
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("hold_rd_valid", instr_valid, 0);
        chk("hold_rd_addr", imem_addr, 32'h100);
        fetch_ack(0, 32'h100, dat(32'h100));
        accept();

        // redirect in FETCH without ack, drain two cycles later
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        chk("dr_lden", load_en, 1);
        chk("dr_load", load, 32'h200);
        chk("dr_pcnx", pc_next, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("dr_req", imem_req, 1);
        chk("dr_addr", imem_addr, 32'h104);
        chk("dr_valid", instr_valid, 0);
        chk("dr_lden0", load_en, 0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("dr_ack_req", imem_req, 1);
        chk("dr_ack_pcnx", pc_next, 0);
        chk("dr_ack_addr", imem_addr, 32'h104);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        chk("dr_new_addr", imem_addr, 32'h200);
        chk("dr_new_req", imem_req, 1);
        chk("dr_new_valid", instr_valid, 0);
        chk("dr_instr_kept", instr, dat(32'h100));
        fetch_ack(0, 32'h200, dat(32'h200));
        accept();

        // misaligned redirect in FETCH with ack in the same cycle
        imem_ack        = 1'b1;
        imem_rdata      = 32'hBAD0_0001;
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        #1;
        chk("mis_pcnx", pc_next, 0);
`ifdef PC_FETCH_CTRL_MISALIGN_CHECK_EN
        chk("mis_lden", load_en, 0);
        tick();
        imem_ack        = 1'b0;
        redirect_target = 32'h300;
        #1;
        chk("flt_fault", fault, 1);
        chk("flt_req", imem_req, 0);
        chk("flt_valid", instr_valid, 0);
        chk("flt_lden", load_en, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("flt_sticky", fault, 1);
        chk("flt_req2", imem_req, 0);
`else
        chk("mis_lden", load_en, 1);
        chk("mis_load", load, 32'h200);
        chk("mis_fault", fault, 0);
        tick();
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        #1;
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_req", imem_req, 1);
        chk("mis_valid", instr_valid, 0);
        fetch_ack(0, 32'h200, 32'h5555_0013);
        accept();
`endif

        // async reset in DRAIN, late ack afterwards
        do_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_drain_req", imem_req, 1);
        clr_n = 1'b0;
        #1;
        chk_all_zero("async");
        tick();
        clr_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0002;
        #1;
        chk("late_req", imem_req, 0);
        chk("late_pcnx", pc_next, 0);
        chk("late_valid", instr_valid, 0);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, RESET_PC);
        chk("restart_instr", instr, 0);

        // redirect to the top word, PC wraps to 0
        fetch_ack(0, 32'h0, dat(32'h0));
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        #1;
        chk("wrap_lden", load_en, 1);
        drop_expected();
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        fetch_ack(0, 32'hFFFF_FFFC, dat(32'hFFFF_FFFC));
        accept();
        chk("wrap_zero", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
